pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32 pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers by generating their hold, bubble and flush controls. It detects three conditions: load-use hazards, taken-branch redirects and multi-cycle data-memory waits. It also runs a memory-wait watchdog FSM and saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if: hazard inputs and pipeline-register controls. Rev 1.0
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_flush;
  logic             id_ex_hold;
  logic             id_ex_bubble;
  logic             ex_mem_hold;
  logic             mem_wb_bubble;
  logic [1:0]       state;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_mem_hold, mem_wb_bubble, state, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_mem_hold, mem_wb_bubble, state, mem_err, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl: stall/flush control with memory-wait watchdog. Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_hazard_ctrl_if.slave hz_io
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_e;

  localparam logic [7:0]       c_timeout = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_e           state_q;
  logic [7:0]       wcnt_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_wait, halt, freeze, load_use, flush, lu_stall;
  logic stall_now, flush_now, freeze_now;

  assign mem_wait = (state_q != ERR) & hz_io.mem_req & ~hz_io.mem_ready;
  assign halt     = (state_q == ERR);
  assign freeze   = mem_wait | halt;
  assign load_use = hz_io.ex_mem_read & (hz_io.ex_rd != 5'd0) &
                    ((hz_io.id_use_rs1 & (hz_io.id_rs1 == hz_io.ex_rd)) |
                     (hz_io.id_use_rs2 & (hz_io.id_rs2 == hz_io.ex_rd)));
  // Freeze beats branch: EX is held, so the branch is re-presented next cycle.
  assign flush    = hz_io.ex_branch_taken & ~freeze;
  assign lu_stall = load_use & ~flush & ~freeze;

  assign stall_now  = ~reset & (freeze | lu_stall);
  assign flush_now  = ~reset & flush;
  assign freeze_now = ~reset & freeze;

  assign hz_io.pc_hold       = stall_now;
  assign hz_io.if_id_hold    = stall_now;
  assign hz_io.if_id_flush   = flush_now;
  assign hz_io.id_ex_hold    = freeze_now;
  assign hz_io.ex_mem_hold   = freeze_now;
  assign hz_io.mem_wb_bubble = freeze_now;
  assign hz_io.id_ex_bubble  = ~reset & (flush | lu_stall);
  assign hz_io.state         = state_q;
  assign hz_io.mem_err       = mem_err_q;
  assign hz_io.stall_cnt     = stall_cnt_q;
  assign hz_io.flush_cnt     = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      wcnt_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            wcnt_q  <= 8'd1;
            state_q <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            wcnt_q  <= 8'd0;
            state_q <= RUN;
          end else if (wcnt_q + 8'd1 == c_timeout) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          wcnt_q  <= 8'd0;
          state_q <= RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_now && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + c_cnt_one;
    if (flush_now && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + c_cnt_one;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl: directed and random checks against a run-length model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Model state: error flag, length of the current memory-wait run, counts.
  bit m_err;
  int m_run;
  int m_stall;
  int m_flush;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hif ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(T),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz_io(hif)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hif.id_rs1          = 5'd0;
    hif.id_rs2          = 5'd0;
    hif.id_use_rs1      = 1'b0;
    hif.id_use_rs2      = 1'b0;
    hif.ex_rd           = 5'd0;
    hif.ex_mem_read     = 1'b0;
    hif.ex_branch_taken = 1'b0;
    hif.mem_req         = 1'b0;
    hif.mem_ready       = 1'b0;
  endtask

  task automatic lu_in(logic [4:0] r);
    hif.ex_mem_read = 1'b1;
    hif.ex_rd       = r;
    hif.id_rs2      = r;
    hif.id_use_rs2  = 1'b1;
  endtask

  // One clock cycle: predict from the rules, compare, clock, advance the model.
  task automatic step();
    bit wt, frz, lu, fl, lus, hold;
    logic [6:0] exp_ctl, obs_ctl;
    logic [1:0] exp_st;
    #2;
    wt  = !m_err && hif.mem_req && !hif.mem_ready;
    frz = wt || m_err;
    lu  = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
          ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
           (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
    fl  = hif.ex_branch_taken && !frz;
    lus = lu && !fl && !frz;
    hold = frz || lus;
    if (reset) exp_ctl = 7'd0;
    else exp_ctl = {hold, hold, fl, frz, fl || lus, frz, frz};
    obs_ctl = {hif.pc_hold, hif.if_id_hold, hif.if_id_flush, hif.id_ex_hold,
               hif.id_ex_bubble, hif.ex_mem_hold, hif.mem_wb_bubble};
    exp_st = m_err ? 2'b10 : (m_run > 0 ? 2'b01 : 2'b00);
    check("ctl", 32'(obs_ctl), 32'(exp_ctl));
    check("state", 32'(hif.state), 32'(exp_st));
    check("mem_err", 32'(hif.mem_err), 32'(m_err));
    check("stall_cnt", 32'(hif.stall_cnt), m_stall);
    check("flush_cnt", 32'(hif.flush_cnt), m_flush);
    @(posedge clk);
    #1;
    if (reset) begin
      m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (hold && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
      if (wt) begin
        m_run++;
        if (m_run == T) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
    step();
    reset = 1'b0;
    step();

    // Load-use on rs2, then x0 destination never stalls.
    lu_in(5'd5);
    #1; check("lu_pc_hold", 32'(hif.pc_hold), 1); check("lu_bubble", 32'(hif.id_ex_bubble), 1);
    step();
    idle();
    #1; check("lu_cnt", 32'(hif.stall_cnt), 1); check("lu_one_cycle", 32'(hif.pc_hold), 0);
    step();
    lu_in(5'd0);
    #1; check("x0_no_stall", 32'(hif.pc_hold), 0);
    step();
    idle();
    #1; check("x0_cnt", 32'(hif.stall_cnt), 1);

    // Branch together with load-use gives flush only.
    do_reset();
    lu_in(5'd7);
    hif.ex_branch_taken = 1'b1;
    #1; check("br_flush", 32'(hif.if_id_flush), 1); check("br_no_hold", 32'(hif.pc_hold), 0);
    check("br_bubble", 32'(hif.id_ex_bubble), 1);
    step();
    idle();
    #1; check("br_fcnt", 32'(hif.flush_cnt), 1); check("br_scnt", 32'(hif.stall_cnt), 0);

    // Three-cycle memory wait.
    do_reset();
    hif.mem_req = 1'b1;
    repeat (3) begin
      #1; check("mw_freeze", 32'(hif.id_ex_hold), 1);
      step();
    end
    hif.mem_ready = 1'b1;
    #1; check("mw_release", 32'(hif.pc_hold), 0); check("mw_state_wait", 32'(hif.state), 1);
    step();
    idle();
    #1; check("mw_scnt", 32'(hif.stall_cnt), 3); check("mw_err", 32'(hif.mem_err), 0);
    check("mw_state_run", 32'(hif.state), 0);

    // Branch held through a two-cycle wait.
    do_reset();
    hif.ex_branch_taken = 1'b1;
    hif.mem_req = 1'b1;
    repeat (2) begin
      #1; check("bw_no_flush", 32'(hif.if_id_flush), 0);
      step();
    end
    hif.mem_ready = 1'b1;
    #1; check("bw_flush", 32'(hif.if_id_flush), 1);
    step();
    idle();
    step();

    // Watchdog trip and recovery by reset.
    do_reset();
    hif.mem_req = 1'b1;
    repeat (T) step();
    #1; check("wd_state", 32'(hif.state), 2); check("wd_err", 32'(hif.mem_err), 1);
    hif.mem_ready = 1'b1;
    #1; check("wd_holds", 32'({hif.pc_hold, hif.if_id_hold, hif.id_ex_hold,
                               hif.ex_mem_hold, hif.mem_wb_bubble}), 32'h1f);
    step();
    idle();
    step();
    do_reset();
    #1; check("rst_state", 32'(hif.state), 0); check("rst_err", 32'(hif.mem_err), 0);
    check("rst_scnt", 32'(hif.stall_cnt), 0); check("rst_fcnt", 32'(hif.flush_cnt), 0);

    // Counter saturation.
    lu_in(5'd9);
    repeat (20) step();
    idle();
    #1; check("sat_scnt", 32'(hif.stall_cnt), CMAX);
    step();

    // Random traffic with small register numbers to provoke matches.
    repeat (400) begin
      hif.id_rs1          = 5'($urandom_range(0, 3));
      hif.id_rs2          = 5'($urandom_range(0, 3));
      hif.id_use_rs1      = 1'($urandom_range(0, 1));
      hif.id_use_rs2      = 1'($urandom_range(0, 1));
      hif.ex_rd           = 5'($urandom_range(0, 3));
      hif.ex_mem_read     = 1'($urandom_range(0, 1));
      hif.ex_branch_taken = ($urandom_range(0, 3) == 0);
      hif.mem_req         = 1'($urandom_range(0, 1));
      hif.mem_ready       = ($urandom_range(0, 9) < 4);
      reset               = ($urandom_range(0, 39) == 0);
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
